// File: rtl/pipe_stage_hs_pkg.sv
// Shared types for the handshaked inter-stage register and the stage payloads it carries.
package pipe_stage_hs_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    typedef logic [31:0] rv32i_pc_word;
    typedef logic [31:0] rv32i_instr_word;
    typedef logic [15:0] rv32i_control_word;

    // Per-stage payloads; the instantiating stage sets WIDTH = $bits(<struct>).
    typedef struct packed {
        rv32i_pc_word    pc;
        rv32i_instr_word instr;
    } if_id_t;

    typedef struct packed {
        rv32i_pc_word      pc;
        rv32i_control_word ctrl;
        logic [31:0]       rs1_val;
        logic [31:0]       rs2_val;
        logic [31:0]       imm;
    } id_ex_t;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipe_stage_hs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count up on inc, hold at all-ones, clear on request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline register with optional 2-entry skid buffer, flush,
// occupancy output and a saturating stall-cycle counter.
//
// state      | meaning
// PIPE_EMPTY | nothing held, out_valid low
// PIPE_BUSY  | one beat in main register, presented downstream
// PIPE_FULL  | main presented, overflow beat parked in skid, in_ready low
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_cycles
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    if (SKID != 0) begin : g_skid
        pipe_state_e      state;
        pipe_state_e      state_nxt;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             rdy_q;

        // State register; in_ready is registered from the next state so it
        // never depends combinationally on out_ready.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= PIPE_EMPTY;
                rdy_q <= 1'b0;
            end else begin
                state <= state_nxt;
                rdy_q <= (state_nxt != PIPE_FULL);
            end
        end

        // Next-state decode; flush overrides every transition.
        always_comb begin
            state_nxt = state;
            if (flush) begin
                state_nxt = PIPE_EMPTY;
            end else begin
                case (state)
                    PIPE_EMPTY: if (in_fire) state_nxt = PIPE_BUSY;
                    PIPE_BUSY: begin
                        if (in_fire && !out_fire)      state_nxt = PIPE_FULL;
                        else if (!in_fire && out_fire) state_nxt = PIPE_EMPTY;
                    end
                    PIPE_FULL:  if (out_fire) state_nxt = PIPE_BUSY;
                    default:    state_nxt = PIPE_EMPTY;
                endcase
            end
        end

        // Payload movement; contents are left alone on flush (invalid anyway).
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                main_q <= '0;
                skid_q <= '0;
            end else if (!flush) begin
                case (state)
                    PIPE_EMPTY: if (in_fire) main_q <= in_data;
                    PIPE_BUSY: begin
                        if (in_fire && out_fire) main_q <= in_data;
                        else if (in_fire)        skid_q <= in_data;
                    end
                    PIPE_FULL:  if (out_fire) main_q <= skid_q;
                    default:    ;
                endcase
            end
        end

        // Outputs decoded from state.
        always_comb begin
            in_ready  = rdy_q;
            out_data  = main_q;
            out_valid = 1'b0;
            occupancy = 2'd0;
            case (state)
                PIPE_BUSY: begin
                    out_valid = 1'b1;
                    occupancy = 2'd1;
                end
                PIPE_FULL: begin
                    out_valid = 1'b1;
                    occupancy = 2'd2;
                end
                default: ;
            endcase
        end
    end else begin : g_noskid
        logic [WIDTH-1:0] main_q;
        logic             valid_q;

        // Single register: load on accept, drop valid when taken with no refill.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                main_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                main_q  <= in_data;
                valid_q <= 1'b1;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        // Ready passes straight through from downstream in this build.
        always_comb begin
            in_ready  = !valid_q || out_ready;
            out_valid = valid_q;
            out_data  = main_q;
            occupancy = {1'b0, valid_q};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .clr   (clr_stats),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed checks for pipe_stage_hs: skid build, 4-bit counter build, no-skid build.
module tb_pipe_stage_hs;

    logic clk;
    logic rst;

    // skid build, 32-bit stall counter
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
    logic [31:0] a_in_data, a_out_data, a_stall;
    logic [1:0]  a_occ;

    // skid build, 4-bit stall counter
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_stall;
    logic [1:0]  s_occ;

    // no-skid build
    logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_clr;
    logic [31:0] z_in_data, z_out_data, z_stall;
    logic [1:0]  z_occ;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_hs #(.WIDTH(32), .SKID(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .clr_stats(a_clr), .stall_cycles(a_stall)
    );

    pipe_stage_hs #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ), .clr_stats(s_clr), .stall_cycles(s_stall)
    );

    pipe_stage_hs #(.WIDTH(32), .SKID(0), .CNT_W(32)) dut_z (
        .clk(clk), .rst(rst), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .occupancy(z_occ), .clr_stats(z_clr), .stall_cycles(z_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {a_flush, a_in_valid, a_out_ready, a_clr} = '0;
        {s_flush, s_in_valid, s_out_ready, s_clr} = '0;
        {z_flush, z_in_valid, z_out_ready, z_clr} = '0;
        a_in_data = '0; s_in_data = '0; z_in_data = '0;

        // reset values
        tick(); tick();
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_occ", {30'd0, a_occ}, 32'd0);
        chk("rst_stall", a_stall, 32'd0);
        chk("rst_in_ready_skid", {31'd0, a_in_ready}, 32'd0);
        chk("rst_in_ready_noskid", {31'd0, z_in_ready}, 32'd1);

        // release: skid build raises in_ready on the first edge afterwards
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk("rel_in_ready_post", {31'd0, a_in_ready}, 32'd1);

        // single-beat latency
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF;
        tick();
        a_in_valid = 1'b0;
        chk("lat_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("lat_out_data", a_out_data, 32'hDEADBEEF);
        chk("lat_occ", {30'd0, a_occ}, 32'd1);
        tick();
        chk("lat_drain_valid", {31'd0, a_out_valid}, 32'd0);
        chk("lat_drain_occ", {30'd0, a_occ}, 32'd0);

        // streaming 1..16 back-to-back
        a_in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_in_data = i;
            tick();
            chk("stream_valid", {31'd0, a_out_valid}, 32'd1);
            chk("stream_data", a_out_data, i);
            chk("stream_in_ready", {31'd0, a_in_ready}, 32'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", {31'd0, a_out_valid}, 32'd0);
        chk("stream_stall", a_stall, 32'd0);

        // skid fill with downstream stalled
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
        tick();
        a_in_data = 32'hB;
        chk("fill_ready_busy", {31'd0, a_in_ready}, 32'd1);
        chk("fill_stall_1st", a_stall, 32'd0);
        tick();
        a_in_valid = 1'b0;
        chk("fill_occ", {30'd0, a_occ}, 32'd2);
        chk("fill_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("fill_head", a_out_data, 32'hA);
        chk("fill_stall_a", a_stall, 32'd1);
        tick();
        chk("fill_stall_b", a_stall, 32'd2);
        chk("fill_head_hold", a_out_data, 32'hA);
        a_out_ready = 1'b1;
        #1;
        chk("pop_first", a_out_data, 32'hA);
        tick();
        chk("pop_second", a_out_data, 32'hB);
        chk("pop_second_valid", {31'd0, a_out_valid}, 32'd1);
        chk("pop_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("pop_occ", {30'd0, a_occ}, 32'd1);
        tick();
        chk("pop_empty", {31'd0, a_out_valid}, 32'd0);
        chk("pop_stall_hold", a_stall, 32'd2);

        // flush from FULL with a beat offered
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
        tick();
        a_in_data = 32'hB;
        tick();
        chk("fl_full_occ", {30'd0, a_occ}, 32'd2);
        a_flush = 1'b1; a_in_data = 32'hC;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("fl_occ", {30'd0, a_occ}, 32'd0);
        chk("fl_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("fl_stall_kept", a_stall, 32'd4);
        a_out_ready = 1'b1;
        tick();
        chk("fl_no_c", {31'd0, a_out_valid}, 32'd0);

        // flush from BUSY discards an accepted beat
        a_in_valid = 1'b1; a_in_data = 32'hD; a_out_ready = 1'b0;
        tick();
        a_flush = 1'b1; a_in_data = 32'hE;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flb_out_valid", {31'd0, a_out_valid}, 32'd0);
        tick();
        chk("flb_no_e", {31'd0, a_out_valid}, 32'd0);

        // clear stats
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_stall", a_stall, 32'd0);

        // async reset mid-operation
        a_in_valid = 1'b1; a_in_data = 32'hF0F0; a_out_ready = 1'b0;
        tick(); tick();
        a_in_valid = 1'b0;
        chk("mid_occ_pre", {30'd0, a_occ}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mid_occ", {30'd0, a_occ}, 32'd0);
        chk("mid_data", a_out_data, 32'd0);
        chk("mid_stall", a_stall, 32'd0);
        chk("mid_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_ready", {31'd0, a_in_ready}, 32'd1);
        chk("mid_rel_valid", {31'd0, a_out_valid}, 32'd0);

        // saturation on the 4-bit counter
        s_in_valid = 1'b1; s_in_data = 32'h55;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", {28'd0, s_stall}, 32'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", {28'd0, s_stall}, 32'hF);
        chk("sat_data_hold", s_out_data, 32'h55);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("sat_clr_wins", {28'd0, s_stall}, 32'h0);
        tick();
        chk("sat_after_clr", {28'd0, s_stall}, 32'h1);

        // no-skid build
        z_in_valid = 1'b1; z_in_data = 32'h77;
        tick();
        z_in_data = 32'h99;
        chk("z_load_valid", {31'd0, z_out_valid}, 32'd1);
        chk("z_load_data", z_out_data, 32'h77);
        chk("z_occ", {30'd0, z_occ}, 32'd1);
        chk("z_ready_stalled", {31'd0, z_in_ready}, 32'd0);
        tick();
        chk("z_hold", z_out_data, 32'h77);
        z_out_ready = 1'b1;
        #1;
        chk("z_ready_comb", {31'd0, z_in_ready}, 32'd1);
        tick();
        chk("z_next", z_out_data, 32'h99);
        for (int i = 0; i < 4; i++) begin
            z_in_data = 32'h100 + i;
            tick();
            chk("z_stream_valid", {31'd0, z_out_valid}, 32'd1);
            chk("z_stream_data", z_out_data, 32'h100 + i);
        end
        z_in_valid = 1'b0;
        tick();
        chk("z_drain", {31'd0, z_out_valid}, 32'd0);
        chk("z_drain_occ", {30'd0, z_occ}, 32'd0);
        chk("z_stall", z_stall, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
